// File: rtl/seg_disp_ctrl_pkg.sv
// Shared constants and types for the seven-segment display feeder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package seg_disp_ctrl_pkg;

    // Register map
    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_COMMIT = 2'd2;

    // Control register field positions
    localparam int SW_LSB       = 0;
    localparam int SW_MSB       = 1;
    localparam int MASK_LSB     = 2;
    localparam int MASK_MSB     = 5;
    localparam int BLINK_EN_BIT = 6;

    // Hex mode, lower half-word
    localparam logic [1:0] SW_RESET = 2'b01;

    // Read-back layout of the control/status register
    typedef struct packed {
        logic [22:0] rsvd;
        logic        pending;
        logic        blink_phase;
        logic        blink_en;
        logic [3:0]  blink_mask;
        logic [1:0]  sw;
    } ctrl_rd_t;

endpackage

// File: rtl/seg_disp_ctrl_if.sv
// Polled CPU register bus: single-cycle write strobe plus combinational read.
// Latency: writes land on the next clk edge; reads are same-cycle.
// Backpressure: none; the slave always accepts writes.
interface seg_disp_ctrl_if;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output wr_en, output addr, output wdata, input rdata);
    modport slave  (input wr_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/seg_scan_timer.sv
// Digit scan timer: prescaler, 2-bit digit index and one-cycle frame_end pulse.
// Latency: each digit index held exactly SCAN_DIV cycles; tick/frame_end are combinational.
// Backpressure: none; free-running.
module seg_scan_timer #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       clr_n,
    output logic [1:0] o_scan,
    output logic       o_tick,
    output logic       o_frame_end
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_scan;
    logic          w_tick;

    assign w_tick      = (r_presc == PRESC_MAX);
    assign o_tick      = w_tick;
    assign o_frame_end = w_tick & (r_scan == 2'd3);
    assign o_scan      = r_scan;

    // Prescaler wraps at SCAN_DIV-1 so it never exceeds its limit
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Digit index advances on every tick, wrapping 3->0 naturally
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_scan <= 2'd0;
        end else if (w_tick) begin
            r_scan <= r_scan + 2'd1;
        end
    end

endmodule

// File: rtl/seg_disp_ctrl.sv
// Display feeder: shadow/commit value register, mode/blink control, scan index.
// Latency: writes visible next cycle; shadow commits at frame boundary (or immediately via commit reg).
// Backpressure: none; every bus write is accepted in the cycle it is strobed.
module seg_disp_ctrl
    import seg_disp_ctrl_pkg::*;
#(
    parameter int          SCAN_DIV     = 100000,
    parameter int          BLINK_FRAMES = 64,
    parameter logic [31:0] INIT_VALUE   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   clr_n,
    seg_disp_ctrl_if.slave         bus,
    output logic [31:0]            disp_num,
    output logic [1:0]             SW,
    output logic [1:0]             Scanning,
    output logic [3:0]             blank_an,
    output logic                   pending
);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [31:0] r_disp_num;
    logic [31:0] r_shadow;
    logic        r_pending;
    logic [1:0]  r_sw;
    logic        r_blink_en;
    logic [3:0]  r_blink_mask;
    logic [7:0]  r_blink_cnt;
    logic        r_blink_phase;
    logic [3:0]  r_blank_an;

    logic        w_frame_end;
    logic        w_tick;
    logic [1:0]  w_scan;
    logic        w_wr_value;
    logic        w_wr_ctrl;
    logic        w_wr_commit;
    logic        w_commit;
    ctrl_rd_t    w_ctrl_rd;

    seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk         (clk),
        .clr_n       (clr_n),
        .o_scan      (w_scan),
        .o_tick      (w_tick),
        .o_frame_end (w_frame_end)
    );

    assign w_wr_value  = bus.wr_en & (bus.addr == ADDR_VALUE);
    assign w_wr_ctrl   = bus.wr_en & (bus.addr == ADDR_CTRL);
    assign w_wr_commit = bus.wr_en & (bus.addr == ADDR_COMMIT);
    // Debug commit and frame-boundary commit collapse into one transfer
    assign w_commit    = w_wr_commit | (w_frame_end & r_pending);

    // Commit path: disp_num always takes the pre-write shadow
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_disp_num <= INIT_VALUE;
        end else if (w_commit) begin
            r_disp_num <= r_shadow;
        end
    end

    // Shadow and pending: a new write re-arms pending even on a commit edge
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_shadow  <= INIT_VALUE;
            r_pending <= 1'b0;
        end else if (w_wr_value) begin
            r_shadow  <= bus.wdata;
            r_pending <= 1'b1;
        end else if (w_commit) begin
            r_pending <= 1'b0;
        end
    end

    // Control register fields
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sw         <= SW_RESET;
            r_blink_mask <= 4'b0000;
            r_blink_en   <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_sw         <= bus.wdata[SW_MSB:SW_LSB];
            r_blink_mask <= bus.wdata[MASK_MSB:MASK_LSB];
            r_blink_en   <= bus.wdata[BLINK_EN_BIT];
        end
    end

    // Blink frame counter and phase; disabling blink restarts both
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= 1'b0;
        end else if (w_wr_ctrl && !bus.wdata[BLINK_EN_BIT]) begin
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_en && w_frame_end) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= 8'd0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 8'd1;
            end
        end
    end

    // Registered blank request so the driver sees a glitch-free AN mask
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_blank_an <= 4'b0000;
        end else begin
            r_blank_an <= r_blink_mask & {4{r_blink_en & r_blink_phase}};
        end
    end

    // Status/control read-back image
    always_comb begin
        w_ctrl_rd             = '0;
        w_ctrl_rd.pending     = r_pending;
        w_ctrl_rd.blink_phase = r_blink_phase;
        w_ctrl_rd.blink_en    = r_blink_en;
        w_ctrl_rd.blink_mask  = r_blink_mask;
        w_ctrl_rd.sw          = r_sw;
    end

    // Combinational register read; value address returns the committed number
    always_comb begin
        bus.rdata = 32'h0000_0000;
        case (bus.addr)
            ADDR_VALUE:  bus.rdata = r_disp_num;
            ADDR_CTRL:   bus.rdata = w_ctrl_rd;
            ADDR_COMMIT: bus.rdata = r_shadow;
            default:     bus.rdata = 32'h0000_0000;
        endcase
    end

    assign disp_num = r_disp_num;
    assign SW       = r_sw;
    assign Scanning = w_scan;
    assign blank_an = r_blank_an;
    assign pending  = r_pending;

    logic w_unused;
    assign w_unused = w_tick;

endmodule
